// File: rtl/npu_cmd_dispatcher.sv
// NPU command dispatcher: turns decoded bus accesses into memory strobes,
// timed OMEM reads and engine start/done handshakes with a watchdog.
module npu_cmd_dispatcher #(
   parameter int DWidth     = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int LOCAL_AW   = 16,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [3:0]            op_type_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DWidth-1:0]     wdata_i,
   output logic                  ready_o,
   output logic                  imem_we_o,
   output logic                  wmem_we_o,
   output logic                  bmem_we_o,
   output logic [LOCAL_AW-1:0]   mem_addr_o,
   output logic [DWidth-1:0]     mem_wdata_o,
   output logic                  omem_re_o,
   input  logic [DWidth-1:0]     omem_rdata_i,
   output logic [DWidth-1:0]     rdata_o,
   output logic                  rvalid_o,
   output logic [DWidth-1:0]     para_o,
   output logic                  os_start_o,
   output logic                  move_start_o,
   input  logic                  engine_done_i,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   localparam logic [3:0] OP_IMEM = 4'b1000;
   localparam logic [3:0] OP_WMEM = 4'b1001;
   localparam logic [3:0] OP_BMEM = 4'b1010;
   localparam logic [3:0] OP_OMEM = 4'b1011;
   localparam logic [3:0] OP_PARA = 4'b1100;
   localparam logic [3:0] OP_OS   = 4'b1111;
   localparam logic [3:0] OP_MOVE = 4'b0001;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_RESP,
      RUN
   } state_t;

   state_t state, state_nx;

   logic [CW-1:0]       cnt, cnt_nx;
   logic                imem_nx, wmem_nx, bmem_nx;
   logic                re_nx, rvalid_nx;
   logic                os_nx, mv_nx;
   logic                busy_nx, err_nx;
   logic [LOCAL_AW-1:0] addr_nx;
   logic [DWidth-1:0]   wdata_nx, rdata_nx, para_nx;
   logic [LOCAL_AW-1:0] laddr;
   logic                addr_unused;

   assign laddr       = addr_i[LOCAL_AW-1:0];
   assign addr_unused = ^addr_i[ADDR_WIDTH-1:LOCAL_AW];
   assign ready_o     = (state == IDLE);

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      imem_nx   = 1'b0;
      wmem_nx   = 1'b0;
      bmem_nx   = 1'b0;
      re_nx     = 1'b0;
      rvalid_nx = 1'b0;
      os_nx     = 1'b0;
      mv_nx     = 1'b0;
      err_nx    = err_o;
      addr_nx   = mem_addr_o;
      wdata_nx  = mem_wdata_o;
      rdata_nx  = rdata_o;
      para_nx   = para_o;
      case (state)
         IDLE: begin
            case (op_type_i)
               OP_IMEM: begin
                  imem_nx  = 1'b1;
                  addr_nx  = laddr;
                  wdata_nx = wdata_i;
               end
               OP_WMEM: begin
                  wmem_nx  = 1'b1;
                  addr_nx  = laddr;
                  wdata_nx = wdata_i;
               end
               OP_BMEM: begin
                  bmem_nx  = 1'b1;
                  addr_nx  = laddr;
                  wdata_nx = wdata_i;
               end
               OP_OMEM: begin
                  re_nx    = 1'b1;
                  addr_nx  = laddr;
                  state_nx = RD_WAIT;
               end
               OP_PARA: para_nx = wdata_i;
               OP_OS: begin
                  os_nx    = 1'b1;
                  cnt_nx   = '0;
                  state_nx = RUN;
               end
               OP_MOVE: begin
                  mv_nx    = 1'b1;
                  cnt_nx   = '0;
                  state_nx = RUN;
               end
               default: ;
            endcase
         end
         RD_WAIT: begin
            rvalid_nx = 1'b1;
            rdata_nx  = omem_rdata_i;
            state_nx  = RD_RESP;
         end
         RD_RESP: state_nx = IDLE;
         RUN: begin
            // cnt is still zero in the start cycle, so done there is ignored
            if (engine_done_i && (cnt != '0)) begin
               state_nx = IDLE;
            end else if (cnt == CNT_MAX) begin
               err_nx   = 1'b1;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx == RUN);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         cnt          <= '0;
         imem_we_o    <= 1'b0;
         wmem_we_o    <= 1'b0;
         bmem_we_o    <= 1'b0;
         omem_re_o    <= 1'b0;
         rvalid_o     <= 1'b0;
         os_start_o   <= 1'b0;
         move_start_o <= 1'b0;
         busy_o       <= 1'b0;
         err_o        <= 1'b0;
         mem_addr_o   <= '0;
         mem_wdata_o  <= '0;
         rdata_o      <= '0;
         para_o       <= '0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         imem_we_o    <= imem_nx;
         wmem_we_o    <= wmem_nx;
         bmem_we_o    <= bmem_nx;
         omem_re_o    <= re_nx;
         rvalid_o     <= rvalid_nx;
         os_start_o   <= os_nx;
         move_start_o <= mv_nx;
         busy_o       <= busy_nx;
         err_o        <= err_nx;
         mem_addr_o   <= addr_nx;
         mem_wdata_o  <= wdata_nx;
         rdata_o      <= rdata_nx;
         para_o       <= para_nx;
      end
   end

endmodule

// File: tb/tb_npu_cmd_dispatcher.sv
// Bench for npu_cmd_dispatcher: cycle-indexed reference model plus
// directed scenarios with literal expectations.
module tb_npu_cmd_dispatcher;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  op;
   logic [31:0] addr;
   logic [7:0]  wdata;
   logic        ready, imem_we, wmem_we, bmem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, omem_rdata, rdata, para;
   logic        omem_re, rvalid, os_start, move_start;
   logic        done, busy, err;

   int n_chk = 0;
   int n_fail = 0;
   bit run_cmp = 0;

   // OMEM stand-in: data is a fixed function of the address (0x20 -> 0x3C)
   assign omem_rdata = mem_addr[7:0] ^ 8'h1C;

   always #5 clk = ~clk;

   npu_cmd_dispatcher #(
      .DWidth(8), .ADDR_WIDTH(32), .LOCAL_AW(16), .TIMEOUT(TMO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .op_type_i(op), .addr_i(addr),
      .wdata_i(wdata), .ready_o(ready), .imem_we_o(imem_we),
      .wmem_we_o(wmem_we), .bmem_we_o(bmem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .omem_re_o(omem_re),
      .omem_rdata_i(omem_rdata), .rdata_o(rdata), .rvalid_o(rvalid),
      .para_o(para), .os_start_o(os_start), .move_start_o(move_start),
      .engine_done_i(done), .busy_o(busy), .err_o(err)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: tracks operations by cycle index, not by FSM state
   int   cyc = 0;
   int   m_start = 0;
   int   m_rd_end = -1;
   bit   m_run = 0;
   logic e_imem, e_wmem, e_bmem, e_ore, e_rvalid, e_os, e_mv, e_busy, e_err;
   logic [15:0] e_addr;
   logic [7:0]  e_wdata, e_rdata, e_para;

   task automatic model_reset();
      m_run = 0; m_rd_end = -1;
      e_imem = 0; e_wmem = 0; e_bmem = 0; e_ore = 0; e_rvalid = 0;
      e_os = 0; e_mv = 0; e_busy = 0; e_err = 0;
      e_addr = 0; e_wdata = 0; e_rdata = 0; e_para = 0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            int  c;
            bit  rdy;
            c   = cyc;
            rdy = !m_run && (c > m_rd_end);
            e_imem = 0; e_wmem = 0; e_bmem = 0; e_ore = 0;
            e_rvalid = 0; e_os = 0; e_mv = 0;
            if (c == m_rd_end - 1) begin
               e_rvalid = 1;
               e_rdata  = e_addr[7:0] ^ 8'h1C;
            end
            if (m_run) begin
               if (done && (c - m_start >= 1)) m_run = 0;
               else if (c - m_start == TMO - 1) begin
                  m_run = 0;
                  e_err = 1;
               end
            end
            if (rdy) begin
               case (op)
                  4'h8: begin e_imem = 1; e_addr = addr[15:0]; e_wdata = wdata; end
                  4'h9: begin e_wmem = 1; e_addr = addr[15:0]; e_wdata = wdata; end
                  4'hA: begin e_bmem = 1; e_addr = addr[15:0]; e_wdata = wdata; end
                  4'hB: begin e_ore = 1; e_addr = addr[15:0]; m_rd_end = c + 2; end
                  4'hC: e_para = wdata;
                  4'hF: begin e_os = 1; m_run = 1; m_start = c + 1; end
                  4'h1: begin e_mv = 1; m_run = 1; m_start = c + 1; end
                  default: ;
               endcase
            end
            e_busy = m_run;
            cyc = cyc + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("ready", 32'(ready), 32'(!m_run && (cyc > m_rd_end)));
         chk("imem_we", 32'(imem_we), 32'(e_imem));
         chk("wmem_we", 32'(wmem_we), 32'(e_wmem));
         chk("bmem_we", 32'(bmem_we), 32'(e_bmem));
         chk("mem_addr", 32'(mem_addr), 32'(e_addr));
         chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
         chk("omem_re", 32'(omem_re), 32'(e_ore));
         chk("rvalid", 32'(rvalid), 32'(e_rvalid));
         chk("rdata", 32'(rdata), 32'(e_rdata));
         chk("para", 32'(para), 32'(e_para));
         chk("os_start", 32'(os_start), 32'(e_os));
         chk("move_start", 32'(move_start), 32'(e_mv));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("err", 32'(err), 32'(e_err));
         chk("one_strobe", 32'(int'(imem_we) + int'(wmem_we) + int'(bmem_we) <= 1), 32'(1));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst_n = 0; op = 4'h7; addr = 0; wdata = 0; done = 0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'(1));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_err", 32'(err), 32'(0));
      chk("rst_para", 32'(para), 32'(0));
      chk("rst_addr", 32'(mem_addr), 32'(0));
      rst_n = 1;
      run_cmp = 1;

      // back-to-back writes
      @(negedge clk); op = 4'h8; addr = 32'h1000_0004; wdata = 8'h5A;
      @(negedge clk);
      chk("wr1_imem", 32'(imem_we), 32'(1));
      chk("wr1_wmem", 32'(wmem_we), 32'(0));
      chk("wr1_addr", 32'(mem_addr), 32'h0004);
      chk("wr1_data", 32'(mem_wdata), 32'h5A);
      op = 4'h9; addr = 32'h2000_0010; wdata = 8'hA5;
      @(negedge clk);
      chk("wr2_imem", 32'(imem_we), 32'(0));
      chk("wr2_wmem", 32'(wmem_we), 32'(1));
      chk("wr2_addr", 32'(mem_addr), 32'h0010);
      chk("wr2_data", 32'(mem_wdata), 32'hA5);
      op = 4'h7;

      // OMEM read, with an op presented at N+1 that must be refused
      @(negedge clk); op = 4'hB; addr = 32'h4000_0020;
      @(negedge clk);
      chk("rd_re", 32'(omem_re), 32'(1));
      chk("rd_addr", 32'(mem_addr), 32'h0020);
      chk("rd_ready1", 32'(ready), 32'(0));
      op = 4'h8; addr = 32'h1000_0044; wdata = 8'h11;
      @(negedge clk);
      chk("rd_rvalid", 32'(rvalid), 32'(1));
      chk("rd_rdata", 32'(rdata), 32'h3C);
      chk("rd_ready2", 32'(ready), 32'(0));
      op = 4'h7;
      @(negedge clk);
      chk("rd_rvalid_drop", 32'(rvalid), 32'(0));
      chk("rd_rdata_hold", 32'(rdata), 32'h3C);
      chk("rd_ready3", 32'(ready), 32'(1));
      chk("rd_refused", 32'(imem_we), 32'(0));

      // OS op, done at N+10
      @(negedge clk); op = 4'hF;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk); op = 4'h7;
         if (k == 1) chk("os_start1", 32'(os_start), 32'(1));
         if (k == 2) chk("os_start2", 32'(os_start), 32'(0));
         if (k == 10) chk("os_busy10", 32'(busy), 32'(1));
         if (k == 11) begin
            chk("os_busy11", 32'(busy), 32'(0));
            chk("os_ready11", 32'(ready), 32'(1));
            chk("os_err", 32'(err), 32'(0));
         end
         done = (k == 10);
      end

      // done in the same cycle as the timeout wins
      @(negedge clk); op = 4'hF;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk); op = 4'h7;
         if (k == 16) chk("tie_busy16", 32'(busy), 32'(1));
         if (k == 17) begin
            chk("tie_busy17", 32'(busy), 32'(0));
            chk("tie_err", 32'(err), 32'(0));
            chk("tie_ready", 32'(ready), 32'(1));
         end
         done = (k == 16);
      end

      // move op, early done ignored, watchdog fires
      @(negedge clk); op = 4'h1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk); op = 4'h7;
         if (k == 1) chk("mv_start", 32'(move_start), 32'(1));
         if (k == 16) begin
            chk("mv_busy16", 32'(busy), 32'(1));
            chk("mv_err16", 32'(err), 32'(0));
         end
         if (k == 17) begin
            chk("mv_err17", 32'(err), 32'(1));
            chk("mv_busy17", 32'(busy), 32'(0));
            chk("mv_ready17", 32'(ready), 32'(1));
         end
         if (k == 20) chk("mv_err_sticky", 32'(err), 32'(1));
         done = (k == 1);
      end

      // reset in the middle of an OS run
      @(negedge clk); op = 4'hF;
      @(negedge clk); op = 4'h7;
      @(negedge clk);
      chk("mid_busy", 32'(busy), 32'(1));
      #3 rst_n = 0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_err", 32'(err), 32'(0));
      chk("mid_rst_ready", 32'(ready), 32'(1));
      chk("mid_rst_os", 32'(os_start), 32'(0));
      @(negedge clk); rst_n = 1;
      @(negedge clk); op = 4'hA; addr = 32'h3000_0008; wdata = 8'h66;
      @(negedge clk);
      chk("post_bmem", 32'(bmem_we), 32'(1));
      chk("post_addr", 32'(mem_addr), 32'h0008);
      chk("post_data", 32'(mem_wdata), 32'h66);
      op = 4'h7;

      // no-op, unknown code, then PARA
      @(negedge clk); op = 4'h7; wdata = 8'h21;
      @(negedge clk); op = 4'h5; wdata = 8'h33;
      @(negedge clk);
      chk("unk_os", 32'(os_start), 32'(0));
      chk("unk_para", 32'(para), 32'(0));
      op = 4'hC; wdata = 8'h7F;
      @(negedge clk);
      chk("para_val", 32'(para), 32'h7F);
      chk("para_bmem", 32'(bmem_we), 32'(0));
      op = 4'h7;
      repeat (2) @(negedge clk);

      run_cmp = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/npu_cmd_dispatcher.md
Name: npu_cmd_dispatcher

Overview:
- Sits directly downstream of the NPU address decoder, in the NPU controller. Consumes the decoder's 4-bit `op_type` together with the same bus address and write data.
- Turns each decoded access into one of three actions:
  - a registered write strobe to IMEM, WMEM or BMEM;
  - a timed OMEM read with a response;
  - a start/done handshake to the compute (OS) engine or the data-move engine.
- Holds off new requests while an operation is in flight. A watchdog flags engines that never return done.

Parameters:
- DWidth, 8, bus write-data and OMEM read-data width.
- ADDR_WIDTH, 32, bus address width.
- LOCAL_AW, 16, local memory address width. The local address is `addr_i[LOCAL_AW-1:0]`; all regions are aligned to 2^LOCAL_AW.
- TIMEOUT, 1024, maximum cycles from engine start to `engine_done_i` before an error is raised (must be >= 2).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- op_type_i  input  4  decoder output: 1000 IMEM wr, 1001 WMEM wr, 1010 BMEM wr, 1011 OMEM rd, 1100 PARA wr, 1111 OS start, 0001 move start, 0111 no-op
- addr_i  input  ADDR_WIDTH  bus address, same cycle as `op_type_i`
- wdata_i  input  DWidth  bus write data, same cycle as `op_type_i`
- ready_o  output  1  high when a request is accepted this cycle
- imem_we_o / wmem_we_o / bmem_we_o  output  1 each  single-cycle write strobes
- mem_addr_o  output  LOCAL_AW  local address for strobes and OMEM read
- mem_wdata_o  output  DWidth  write data for strobes
- omem_re_o  output  1  OMEM read enable; the memory has 1-cycle read latency
- omem_rdata_i  input  DWidth  OMEM read data
- rdata_o  output  DWidth  read response data
- rvalid_o  output  1  one-cycle read response valid
- para_o  output  DWidth  parameter register
- os_start_o / move_start_o  output  1 each  one-cycle engine start pulses
- engine_done_i  input  1  active engine finished
- busy_o  output  1  engine operation in flight
- err_o  output  1  sticky watchdog error

Behaviour:
- **Reset** (async, `rst_ni` = 0): FSM goes to IDLE. All strobes, `omem_re_o`, `rvalid_o`, start pulses, `busy_o` and `err_o` go to 0. `mem_addr_o`, `mem_wdata_o`, `rdata_o` and `para_o` go to 0. The watchdog counter goes to 0. Reset asserted mid-operation abandons that operation with no done or response.
- **FSM states:** IDLE, RD_WAIT, RD_RESP, RUN.
- **`ready_o`** = (state == IDLE). It is a combinational function of state only.
- **Accept rule:** a request is accepted at cycle N when `ready_o` = 1 and `op_type_i` is not 0111. Any unlisted code is ignored, i.e. treated as a no-op.
- **Writes (1000/1001/1010):**
  - At N+1 exactly one matching strobe is high for one cycle, with `mem_addr_o` = `addr_i[LOCAL_AW-1:0]` and `mem_wdata_o` = `wdata_i` captured at N.
  - The FSM stays in IDLE, so back-to-back writes every cycle are allowed.
- **PARA (1100):** `para_o` <= `wdata_i` at N+1; no other effect.
- **OMEM read (1011):**
  - IDLE -> RD_WAIT; `omem_re_o` = 1 and `mem_addr_o` are valid at N+1.
  - RD_WAIT -> RD_RESP at N+2. In that cycle `rdata_o` = `omem_rdata_i` (registered) and `rvalid_o` = 1 for exactly one cycle.
  - RD_RESP -> IDLE; the next request is accepted no earlier than N+3.
  - `rdata_o` holds its value after `rvalid_o` drops.
- **Engine ops (1111 or 0001):**
  - IDLE -> RUN. The matching start pulse is high at N+1 only. `busy_o` = 1 from N+1 and the watchdog counter is cleared.
  - In RUN, `engine_done_i` is sampled only from N+2 onward; done at N+1 is ignored.
  - On done: RUN -> IDLE and `busy_o` drops next cycle.
  - Each RUN cycle without done increments the counter. When the counter reaches TIMEOUT-1 without done: `err_o` <= 1 (sticky until reset) and RUN -> IDLE.
  - Done arriving in the same cycle as the timeout takes priority: no error is raised.
- `engine_done_i` in any state other than RUN is ignored.
- All outputs are registered except `ready_o`.

Test Plan:
- **Back-to-back writes.** Reset, then:
  - cycle 0: op=1000, addr=0x1000_0004, wdata=0x5A
  - cycle 1: op=1001, addr=0x2000_0010, wdata=0xA5

  -> imem_we at cycle 1 (addr 0x0004, data 0x5A); wmem_we at cycle 2 (addr 0x0010, data 0xA5); never two strobes in one cycle.
- **OMEM read.** op=1011, addr low=0x0020, memory returns 0x3C -> `omem_re_o` at N+1 with addr 0x0020; `rdata_o`=0x3C and `rvalid_o` at N+2 for one cycle; `ready_o` low N+1..N+2; an op presented at N+1 is not accepted.
- **OS operation.** op=1111, done asserted at N+10 -> `os_start_o` pulses at N+1 only; `busy_o` high N+1..N+10; `ready_o` back high at N+11; `err_o` stays 0.
- **Early done and watchdog.** op=0001 with done pulsed at N+1 only (ignored) and never again, TIMEOUT=16 -> `move_start_o` at N+1; `err_o` rises after 16 RUN cycles and stays high; FSM returns to IDLE.
- **Reset mid-operation.** `rst_ni` low during RUN -> `busy_o`, `err_o` and all pulses are 0 immediately; after release, a write request is accepted normally.
- **No-op and unknown codes.** op=0111, then op=0101 with PARA op=1100 wdata=0x7F -> no strobes or pulses for 0111/0101; `para_o`=0x7F at N+1.
